// File: rtl/drive_ramp_ctrl_if.sv
// Host/driver-side bundle for the drive ramp controller: host configuration and
// events in, half-bridge driver settings and status out.
interface drive_ramp_ctrl_if #(
  parameter int FREQ_BITS  = 19,
  parameter int DUTY_BITS  = 7,
  parameter int PHASE_BITS = 9,
  parameter int STEP_BITS  = 16
);
  logic [FREQ_BITS-1:0]  cfg_freq;
  logic [DUTY_BITS-1:0]  cfg_duty;
  logic [PHASE_BITS-1:0] cfg_phase;
  logic                  cfg_pos_en;
  logic                  cfg_neg_en;
  logic [STEP_BITS-1:0]  cfg_step_per;
  logic                  start;
  logic                  upd;
  logic                  stop;
  logic                  fault;
  logic                  fault_clr;
  logic                  cyc_start;
  logic [FREQ_BITS-1:0]  freq;
  logic [DUTY_BITS-1:0]  duty;
  logic [PHASE_BITS-1:0] phase;
  logic                  pos;
  logic                  neg;
  logic [2:0]            state;
  logic                  busy;
  logic                  ramp_done;

  modport master (
    output cfg_freq, cfg_duty, cfg_phase, cfg_pos_en, cfg_neg_en, cfg_step_per,
    output start, upd, stop, fault, fault_clr, cyc_start,
    input  freq, duty, phase, pos, neg, state, busy, ramp_done
  );

  modport slave (
    input  cfg_freq, cfg_duty, cfg_phase, cfg_pos_en, cfg_neg_en, cfg_step_per,
    input  start, upd, stop, fault, fault_clr, cyc_start,
    output freq, duty, phase, pos, neg, state, busy, ramp_done
  );
endinterface

// File: rtl/drive_ramp_ctrl.sv
// Soft-start / soft-stop sequencer for a fixed-frequency half-bridge driver.
// Duty slews one step per N driver periods; a fault kills the outputs at once.
module drive_ramp_ctrl #(
  parameter int FREQ_BITS   = 19,
  parameter int DUTY_BITS   = 7,
  parameter int PHASE_BITS  = 9,
  parameter int DUTY_SCALE  = 100,
  parameter int PHASE_SCALE = 360,
  parameter int DUTY_STEP   = 1,
  parameter int STEP_BITS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  drive_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SLEW     = 3'd1,
    ST_RUN      = 3'd2,
    ST_SLEW_OFF = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [DUTY_BITS-1:0]  DUTY_MAX  = DUTY_BITS'(DUTY_SCALE);
  localparam logic [PHASE_BITS-1:0] PHASE_MAX = PHASE_BITS'(PHASE_SCALE - 1);
  localparam logic [DUTY_BITS-1:0]  DUTY_INC  = DUTY_BITS'(DUTY_STEP);
  localparam logic [STEP_BITS-1:0]  STEP_ONE  = STEP_BITS'(1);

  state_t                r_state;
  logic [FREQ_BITS-1:0]  r_freq;
  logic [DUTY_BITS-1:0]  r_duty;
  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_pos;
  logic                  r_neg;
  logic                  r_busy;
  logic                  r_ramp_done;
  logic [STEP_BITS-1:0]  r_step_cnt;
  logic [STEP_BITS-1:0]  r_step_per;
  logic [DUTY_BITS-1:0]  r_tgt_duty;
  logic [PHASE_BITS-1:0] r_tgt_phase;

  logic [DUTY_BITS-1:0]  w_clamp_duty;
  logic [PHASE_BITS-1:0] w_clamp_phase;
  logic [STEP_BITS-1:0]  w_clamp_per;
  logic [STEP_BITS-1:0]  w_cnt_inc;
  logic [STEP_BITS-1:0]  w_cnt_next;
  logic                  w_step_hit;
  logic [DUTY_BITS-1:0]  w_gap_up;
  logic [DUTY_BITS-1:0]  w_gap_dn;
  logic [DUTY_BITS-1:0]  w_duty_stepped;
  logic [DUTY_BITS-1:0]  w_duty_next;
  logic                  w_at_tgt;

  assign w_clamp_duty  = (bus.cfg_duty > DUTY_MAX) ? DUTY_MAX : bus.cfg_duty;
  assign w_clamp_phase = (bus.cfg_phase > PHASE_MAX) ? PHASE_MAX : bus.cfg_phase;
  assign w_clamp_per   = (bus.cfg_step_per == {STEP_BITS{1'b0}}) ? STEP_ONE : bus.cfg_step_per;

  // The counter runs 0..step_per-1; the step fires on the pulse that completes a full window.
  assign w_cnt_inc  = r_step_cnt + STEP_ONE;
  assign w_step_hit = (w_cnt_inc >= r_step_per);
  assign w_cnt_next = w_step_hit ? {STEP_BITS{1'b0}} : w_cnt_inc;

  assign w_gap_up = r_tgt_duty - r_duty;
  assign w_gap_dn = r_duty - r_tgt_duty;

  // One saturating step toward the target, never overshooting it.
  always_comb begin
    w_duty_stepped = r_duty;
    if (r_duty < r_tgt_duty) begin
      w_duty_stepped = (w_gap_up < DUTY_INC) ? r_tgt_duty : (r_duty + DUTY_INC);
    end else if (r_duty > r_tgt_duty) begin
      w_duty_stepped = (w_gap_dn < DUTY_INC) ? r_tgt_duty : (r_duty - DUTY_INC);
    end else begin
      w_duty_stepped = r_duty;
    end
  end

  // Completion is judged on the duty that this cyc_start produces.
  assign w_duty_next = w_step_hit ? w_duty_stepped : r_duty;
  assign w_at_tgt    = (w_duty_next == r_tgt_duty);

  // Sequencer state, latched targets and all driver-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_freq      <= {FREQ_BITS{1'b0}};
      r_duty      <= {DUTY_BITS{1'b0}};
      r_phase     <= {PHASE_BITS{1'b0}};
      r_pos       <= 1'b0;
      r_neg       <= 1'b0;
      r_busy      <= 1'b0;
      r_ramp_done <= 1'b0;
      r_step_cnt  <= {STEP_BITS{1'b0}};
      r_step_per  <= {STEP_BITS{1'b0}};
      r_tgt_duty  <= {DUTY_BITS{1'b0}};
      r_tgt_phase <= {PHASE_BITS{1'b0}};
    end else begin
      r_ramp_done <= 1'b0;
      if (bus.fault) begin
        r_state     <= ST_FAULT;
        r_busy      <= 1'b1;
        r_freq      <= {FREQ_BITS{1'b0}};
        r_duty      <= {DUTY_BITS{1'b0}};
        r_phase     <= {PHASE_BITS{1'b0}};
        r_pos       <= 1'b0;
        r_neg       <= 1'b0;
        r_step_cnt  <= {STEP_BITS{1'b0}};
        r_tgt_duty  <= {DUTY_BITS{1'b0}};
        r_tgt_phase <= {PHASE_BITS{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && !bus.stop) begin
              r_state     <= ST_SLEW;
              r_busy      <= 1'b1;
              r_tgt_duty  <= w_clamp_duty;
              r_tgt_phase <= w_clamp_phase;
              r_step_per  <= w_clamp_per;
              r_step_cnt  <= {STEP_BITS{1'b0}};
              r_freq      <= bus.cfg_freq;
              r_phase     <= w_clamp_phase;
              r_pos       <= bus.cfg_pos_en;
              r_neg       <= bus.cfg_neg_en;
              r_duty      <= {DUTY_BITS{1'b0}};
            end
          end
          ST_SLEW: begin
            if (bus.stop) begin
              r_state    <= ST_SLEW_OFF;
              r_tgt_duty <= {DUTY_BITS{1'b0}};
              r_step_cnt <= {STEP_BITS{1'b0}};
            end else if (bus.cyc_start) begin
              r_duty  <= w_duty_next;
              r_phase <= r_tgt_phase;
              if (w_at_tgt) begin
                r_state     <= ST_RUN;
                r_ramp_done <= 1'b1;
                r_step_cnt  <= {STEP_BITS{1'b0}};
              end else begin
                r_step_cnt <= w_cnt_next;
              end
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              r_state    <= ST_SLEW_OFF;
              r_tgt_duty <= {DUTY_BITS{1'b0}};
              r_step_cnt <= {STEP_BITS{1'b0}};
            end else if (bus.upd) begin
              // Phase is applied at the next period boundary, not here.
              r_state     <= ST_SLEW;
              r_tgt_duty  <= w_clamp_duty;
              r_tgt_phase <= w_clamp_phase;
              r_step_per  <= w_clamp_per;
              r_step_cnt  <= {STEP_BITS{1'b0}};
            end
          end
          ST_SLEW_OFF: begin
            if (bus.cyc_start) begin
              if (w_at_tgt) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_duty     <= {DUTY_BITS{1'b0}};
                r_freq     <= {FREQ_BITS{1'b0}};
                r_phase    <= {PHASE_BITS{1'b0}};
                r_pos      <= 1'b0;
                r_neg      <= 1'b0;
                r_step_cnt <= {STEP_BITS{1'b0}};
              end else begin
                r_duty     <= w_duty_next;
                r_step_cnt <= w_cnt_next;
              end
            end
          end
          ST_FAULT: begin
            if (bus.fault_clr) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_freq     <= {FREQ_BITS{1'b0}};
            r_duty     <= {DUTY_BITS{1'b0}};
            r_phase    <= {PHASE_BITS{1'b0}};
            r_pos      <= 1'b0;
            r_neg      <= 1'b0;
            r_step_cnt <= {STEP_BITS{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.freq      = r_freq;
  assign bus.duty      = r_duty;
  assign bus.phase     = r_phase;
  assign bus.pos       = r_pos;
  assign bus.neg       = r_neg;
  assign bus.state     = r_state;
  assign bus.busy      = r_busy;
  assign bus.ramp_done = r_ramp_done;

endmodule

// File: tb/tb_drive_ramp_ctrl.sv
// Bench for drive_ramp_ctrl: directed soft-start/stop/fault/reset scenarios,
// then random traffic, every cycle compared against a behavioural model.
module tb_drive_ramp_ctrl;
  localparam int DS   = 100;
  localparam int PS   = 360;
  localparam int STEP = 1;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  drive_ramp_ctrl_if bus ();

  drive_ramp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model: state codes 0 idle, 1 slew, 2 run, 3 slew_off, 4 fault
  int m_state, m_duty, m_tgt, m_phase, m_tphase, m_per, m_cnt, m_freq, m_pos, m_neg, m_done;
  int cyc_per, cyc_cnt, n_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP) d = STEP;
    if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_tgt = 0; m_phase = 0; m_tphase = 0; m_per = 0;
    m_cnt = 0; m_freq = 0; m_pos = 0; m_neg = 0; m_done = 0;
  endtask

  task automatic model_latch();
    m_tgt    = (int'(bus.cfg_duty) > DS) ? DS : int'(bus.cfg_duty);
    m_tphase = (int'(bus.cfg_phase) > PS - 1) ? PS - 1 : int'(bus.cfg_phase);
    m_per    = (bus.cfg_step_per == 16'd0) ? 1 : int'(bus.cfg_step_per);
    m_cnt    = 0;
  endtask

  // one driver period boundary while ramping (on or off)
  task automatic model_ramp();
    m_cnt++;
    if (m_cnt >= m_per) begin
      m_cnt  = 0;
      m_duty = toward(m_duty, m_tgt);
    end
    if (m_state == 1) m_phase = m_tphase;
    if (m_duty == m_tgt) begin
      m_cnt = 0;
      if (m_state == 1) begin
        m_state = 2;
        m_done  = 1;
      end else begin
        m_state = 0; m_freq = 0; m_phase = 0; m_pos = 0; m_neg = 0;
      end
    end
  endtask

  task automatic model_step();
    m_done = 0;
    if (!rst) begin
      model_reset();
    end else if (bus.fault) begin
      m_state = 4; m_duty = 0; m_pos = 0; m_neg = 0; m_freq = 0; m_phase = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      if (bus.start && !bus.stop) begin
        model_latch();
        m_freq  = int'(bus.cfg_freq);
        m_phase = m_tphase;
        m_pos   = int'(bus.cfg_pos_en);
        m_neg   = int'(bus.cfg_neg_en);
        m_duty  = 0;
        m_state = 1;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (bus.stop) begin
        m_state = 3; m_tgt = 0; m_cnt = 0;
      end else if (m_state == 2) begin
        if (bus.upd) begin
          model_latch();
          m_state = 1;
        end
      end else if (bus.cyc_start) begin
        model_ramp();
      end
    end else if (m_state == 3) begin
      if (bus.cyc_start) model_ramp();
    end else if (m_state == 4) begin
      if (bus.fault_clr) m_state = 0;
    end
  endtask

  task automatic compare_all();
    check("state", 32'(bus.state), 32'(m_state));
    check("duty", 32'(bus.duty), 32'(m_duty));
    check("phase", 32'(bus.phase), 32'(m_phase));
    check("freq", 32'(bus.freq), 32'(m_freq));
    check("pos", 32'(bus.pos), 32'(m_pos));
    check("neg", 32'(bus.neg), 32'(m_neg));
    check("busy", 32'(bus.busy), (m_state != 0) ? 32'd1 : 32'd0);
    check("ramp_done", 32'(bus.ramp_done), 32'(m_done));
  endtask

  // advance one clock: model and DUT see the same inputs at the edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    if (bus.cyc_start && m_state != 0) n_cyc++;
    #1;
    compare_all();
    bus.start     = 1'b0;
    bus.upd       = 1'b0;
    bus.stop      = 1'b0;
    bus.fault_clr = 1'b0;
    cyc_cnt++;
    bus.cyc_start = (cyc_per > 0) && (cyc_cnt % cyc_per == 0);
  endtask

  task automatic set_cfg(input int d, input int ph, input int sp, input logic p, input logic n);
    bus.cfg_freq     = 19'($urandom);
    bus.cfg_duty     = 7'(d);
    bus.cfg_phase    = 9'(ph);
    bus.cfg_step_per = 16'(sp);
    bus.cfg_pos_en   = p;
    bus.cfg_neg_en   = n;
  endtask

  task automatic wait_state(input string tag, input int want, input int budget);
    int i;
    i = 0;
    while (m_state != want && i < budget) begin
      cycle();
      i++;
    end
    check(tag, 32'(bus.state), 32'(want));
  endtask

  task automatic wait_duty(input string tag, input int want, input int budget);
    int i;
    i = 0;
    while (m_duty != want && i < budget) begin
      cycle();
      i++;
    end
    check(tag, 32'(bus.duty), 32'(want));
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.upd = 1'b0; bus.stop = 1'b0; bus.fault = 1'b0;
    bus.fault_clr = 1'b0; bus.cyc_start = 1'b0;
    set_cfg(0, 0, 0, 1'b0, 1'b0);
    model_reset();
    cyc_per = 10; cyc_cnt = 0; n_cyc = 0;
    cycle();
    cycle();
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_duty", 32'(bus.duty), 32'd0);
    rst = 1'b1;
    cycle();

    // soft start: 5 steps, one every 2nd period -> done on the 10th cyc_start
    set_cfg(5, 30, 2, 1'b1, 1'b1);
    bus.start = 1'b1;
    cycle();
    n_cyc = 0;
    wait_state("soft_run", 2, 200);
    check("soft_ncyc", 32'(n_cyc), 32'd10);
    check("soft_duty", 32'(bus.duty), 32'd5);
    bus.stop = 1'b1;
    cycle();
    wait_state("soft_idle", 0, 200);

    // clamping and zero step period
    cyc_per = 2;
    set_cfg(120, 400, 0, 1'b1, 1'b0);
    bus.start = 1'b1;
    cycle();
    check("clamp_phase", 32'(bus.phase), 32'd359);
    wait_state("clamp_run", 2, 400);
    check("clamp_duty", 32'(bus.duty), 32'd100);

    // retarget down to 50, then to 47
    cyc_per = 3;
    set_cfg(50, 90, 1, 1'b1, 1'b0);
    bus.upd = 1'b1;
    cycle();
    wait_state("ret50_run", 2, 400);
    set_cfg(47, 120, 1, 1'b1, 1'b0);
    bus.upd = 1'b1;
    cycle();
    check("ret_slew", 32'(bus.state), 32'd1);
    wait_state("ret47_run", 2, 100);
    check("ret_duty", 32'(bus.duty), 32'd47);
    check("ret_phase", 32'(bus.phase), 32'd120);
    bus.stop = 1'b1;
    cycle();
    wait_state("ret_idle", 0, 400);

    // stop mid-ramp at duty 3
    set_cfg(10, 10, 1, 1'b1, 1'b1);
    bus.start = 1'b1;
    cycle();
    wait_duty("stop_at3", 3, 100);
    bus.stop = 1'b1;
    cycle();
    check("stop_off", 32'(bus.state), 32'd3);
    wait_state("stop_idle", 0, 100);
    check("stop_busy", 32'(bus.busy), 32'd0);
    check("stop_pos", 32'(bus.pos), 32'd0);

    // fault in RUN, start ignored, clear only with fault low
    set_cfg(40, 10, 1, 1'b1, 1'b1);
    bus.start = 1'b1;
    cycle();
    wait_state("flt_run", 2, 300);
    bus.fault = 1'b1;
    cycle();
    check("flt_state", 32'(bus.state), 32'd4);
    check("flt_duty", 32'(bus.duty), 32'd0);
    bus.start = 1'b1;
    cycle();
    bus.fault_clr = 1'b1;
    cycle();
    check("flt_hold", 32'(bus.state), 32'd4);
    bus.fault = 1'b0;
    bus.fault_clr = 1'b1;
    cycle();
    check("flt_clr", 32'(bus.state), 32'd0);

    // asynchronous reset mid-slew, then a clean restart
    set_cfg(30, 10, 2, 1'b1, 1'b1);
    bus.start = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) cycle();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_duty", 32'(bus.duty), 32'd0);
    check("arst_pos", 32'(bus.pos), 32'd0);
    compare_all();
    cycle();
    rst = 1'b1;
    cycle();
    bus.start = 1'b1;
    cycle();
    wait_state("arst_run", 2, 300);
    check("arst_duty_end", 32'(bus.duty), 32'd30);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      set_cfg($urandom_range(0, 127), $urandom_range(0, 511), $urandom_range(0, 3),
              1'($urandom), 1'($urandom));
      if (r < 4) bus.start = 1'b1;
      else if (r < 8) bus.upd = 1'b1;
      else if (r < 10) bus.stop = 1'b1;
      else if (r < 11) bus.fault = 1'b1;
      else if (r < 14) bus.fault_clr = 1'b1;
      if (bus.fault && $urandom_range(0, 9) < 3) bus.fault = 1'b0;
      if ($urandom_range(0, 99) == 0) cyc_per = $urandom_range(0, 6);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
